// File: rtl/imem_port_arbiter.sv
// Instruction-memory port arbiter: the loader owns the port during boot, then fetch has
// priority in run, with a starvation guard that eventually lets the loader through.
module imem_port_arbiter #(
  parameter int unsigned ADDR_W     = 11,
  parameter int unsigned STARVE_MAX = 4
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic              i_boot_done,
  input  logic              i_fetch_req,
  input  logic [31:0]       i_fetch_pc,
  output logic              o_fetch_gnt,
  output logic              o_fetch_stall,
  output logic              o_fetch_rvalid,
  input  logic              i_ld_req,
  input  logic [31:0]       i_ld_addr,
  input  logic [31:0]       i_ld_wdata,
  output logic              o_ld_gnt,
  output logic              o_ld_err,
  output logic              o_mem_en,
  output logic              o_mem_we,
  output logic [ADDR_W-1:0] o_mem_addr,
  output logic [31:0]       o_mem_wdata
);

  localparam int unsigned CntW = $clog2(STARVE_MAX + 1);
  localparam logic [CntW-1:0] StarveMax = CntW'(STARVE_MAX);

  typedef enum logic {StBoot, StRun} state_e;

  state_e          state_q, state_d;
  logic [CntW-1:0] starve_q, starve_d;
  logic            rvalid_q, ld_err_q;

  logic [ADDR_W-1:0] fetch_waddr, ld_waddr;
  logic              ld_illegal;

  assign fetch_waddr = i_fetch_pc[ADDR_W+1:2];
  assign ld_waddr    = i_ld_addr[ADDR_W+1:2];
  assign ld_illegal  = (i_ld_addr[1:0] != 2'b00) || (|i_ld_addr[31:ADDR_W+2]);

  // Fetch addresses are aligned and in range by construction; the remaining bits are dropped.
  logic unused_fetch_pc;
  assign unused_fetch_pc = ^{i_fetch_pc[31:ADDR_W+2], i_fetch_pc[1:0]};

  always_comb begin
    state_d       = state_q;
    starve_d      = starve_q;
    o_fetch_gnt   = 1'b0;
    o_ld_gnt      = 1'b0;
    o_fetch_stall = 1'b1;
    o_mem_en      = 1'b0;
    o_mem_we      = 1'b0;
    o_mem_addr    = ld_waddr;
    o_mem_wdata   = i_ld_wdata;

    if (i_rst_n) begin
      unique case (state_q)
        StBoot: begin
          o_ld_gnt = i_ld_req;
          if (i_boot_done) state_d = StRun;
        end
        StRun: begin
          o_ld_gnt      = i_ld_req && (!i_fetch_req || (starve_q == StarveMax));
          o_fetch_gnt   = i_fetch_req && !o_ld_gnt;
          o_fetch_stall = i_fetch_req && !o_fetch_gnt;
          if (o_ld_gnt) begin
            starve_d = '0;
          end else if (i_ld_req && (starve_q != StarveMax)) begin
            starve_d = starve_q + CntW'(1);
          end
        end
        default: state_d = StBoot;
      endcase

      if (o_fetch_gnt) begin
        o_mem_en   = 1'b1;
        o_mem_addr = fetch_waddr;
      end else if (o_ld_gnt && !ld_illegal) begin
        o_mem_en = 1'b1;
        o_mem_we = 1'b1;
      end
    end
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      state_q  <= StBoot;
      starve_q <= '0;
      rvalid_q <= 1'b0;
      ld_err_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      starve_q <= starve_d;
      rvalid_q <= o_fetch_gnt;
      ld_err_q <= o_ld_gnt && ld_illegal;
    end
  end

  assign o_fetch_rvalid = rvalid_q;
  assign o_ld_err       = ld_err_q;

endmodule

// File: tb/tb_imem_port_arbiter.sv
// Directed bench for imem_port_arbiter: reset, boot load, boot exit, starvation guard,
// illegal loader addresses and reset while running.
module tb_imem_port_arbiter;

  localparam int unsigned ADDR_W = 11;

  logic              clk = 1'b0;
  logic              rst_n;
  logic              boot_done;
  logic              fetch_req;
  logic [31:0]       fetch_pc;
  logic              fetch_gnt, fetch_stall, fetch_rvalid;
  logic              ld_req;
  logic [31:0]       ld_addr, ld_wdata;
  logic              ld_gnt, ld_err;
  logic              mem_en, mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [31:0]       mem_wdata;

  int tests = 0;
  int fails = 0;

  imem_port_arbiter #(.ADDR_W(ADDR_W), .STARVE_MAX(4)) dut (
    .i_clk         (clk),
    .i_rst_n       (rst_n),
    .i_boot_done   (boot_done),
    .i_fetch_req   (fetch_req),
    .i_fetch_pc    (fetch_pc),
    .o_fetch_gnt   (fetch_gnt),
    .o_fetch_stall (fetch_stall),
    .o_fetch_rvalid(fetch_rvalid),
    .i_ld_req      (ld_req),
    .i_ld_addr     (ld_addr),
    .i_ld_wdata    (ld_wdata),
    .o_ld_gnt      (ld_gnt),
    .o_ld_err      (ld_err),
    .o_mem_en      (mem_en),
    .o_mem_we      (mem_we),
    .o_mem_addr    (mem_addr),
    .o_mem_wdata   (mem_wdata)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  logic [31:0] boot_img [3];

  initial begin
    boot_img[0] = 32'h0000_0013;
    boot_img[1] = 32'h0010_0093;
    boot_img[2] = 32'h0020_8113;

    // 1. Reset held for two edges with both requesters active.
    rst_n = 1'b0; boot_done = 1'b0;
    fetch_req = 1'b1; fetch_pc = 32'h0;
    ld_req = 1'b1; ld_addr = 32'h4; ld_wdata = 32'h1234_5678;
    #2;
    chk("rst_stall", 32'(fetch_stall), 32'd1);
    chk("rst_fgnt", 32'(fetch_gnt), 32'd0);
    chk("rst_lgnt", 32'(ld_gnt), 32'd0);
    chk("rst_en", 32'(mem_en), 32'd0);
    tick();
    chk("rst2_we", 32'(mem_we), 32'd0);
    chk("rst2_en", 32'(mem_en), 32'd0);
    chk("rst2_rvalid", 32'(fetch_rvalid), 32'd0);
    chk("rst2_lderr", 32'(ld_err), 32'd0);
    tick();
    rst_n = 1'b1; ld_req = 1'b0;
    #2;
    chk("boot_fgnt", 32'(fetch_gnt), 32'd0);
    chk("boot_stall", 32'(fetch_stall), 32'd1);
    chk("boot_rvalid", 32'(fetch_rvalid), 32'd0);
    chk("boot_idle_en", 32'(mem_en), 32'd0);
    tick();

    // 2. Boot load while fetch keeps requesting.
    for (int i = 0; i < 3; i++) begin
      ld_req = 1'b1; ld_addr = 32'(4 * i); ld_wdata = boot_img[i];
      #2;
      chk("load_gnt", 32'(ld_gnt), 32'd1);
      chk("load_we", 32'(mem_we), 32'd1);
      chk("load_en", 32'(mem_en), 32'd1);
      chk("load_addr", 32'(mem_addr), 32'(i));
      chk("load_wdata", mem_wdata, boot_img[i]);
      chk("load_fgnt", 32'(fetch_gnt), 32'd0);
      tick();
    end

    // 3. Boot exit, then first fetch.
    ld_req = 1'b0; boot_done = 1'b1; fetch_pc = 32'h8;
    #2;
    chk("exit_fgnt", 32'(fetch_gnt), 32'd0);
    tick();
    boot_done = 1'b0;
    #2;
    chk("run_fgnt", 32'(fetch_gnt), 32'd1);
    chk("run_addr", 32'(mem_addr), 32'd2);
    chk("run_we", 32'(mem_we), 32'd0);
    chk("run_stall", 32'(fetch_stall), 32'd0);
    tick();
    #2;
    chk("run_rvalid", 32'(fetch_rvalid), 32'd1);

    // 4. Starvation guard: four denials, then the loader wins once.
    ld_req = 1'b1; ld_addr = 32'h10; ld_wdata = 32'hdead_beef;
    for (int c = 0; c < 4; c++) begin
      #2;
      chk("starve_lgnt", 32'(ld_gnt), 32'd0);
      chk("starve_fgnt", 32'(fetch_gnt), 32'd1);
      tick();
    end
    #2;
    chk("win_lgnt", 32'(ld_gnt), 32'd1);
    chk("win_fgnt", 32'(fetch_gnt), 32'd0);
    chk("win_stall", 32'(fetch_stall), 32'd1);
    chk("win_we", 32'(mem_we), 32'd1);
    chk("win_addr", 32'(mem_addr), 32'd4);
    chk("win_wdata", mem_wdata, 32'hdead_beef);
    tick();
    ld_addr = 32'h14;
    #2;
    chk("regrant_fgnt", 32'(fetch_gnt), 32'd1);
    chk("regrant_lgnt", 32'(ld_gnt), 32'd0);
    chk("regrant_rvalid", 32'(fetch_rvalid), 32'd0);
    tick();

    // 5. Illegal loader addresses; boot_done must be ignored in RUN.
    fetch_req = 1'b0; boot_done = 1'b1;
    ld_req = 1'b1; ld_addr = 32'h6;
    #2;
    chk("mis_gnt", 32'(ld_gnt), 32'd1);
    chk("mis_we", 32'(mem_we), 32'd0);
    chk("mis_en", 32'(mem_en), 32'd0);
    chk("mis_err_pre", 32'(ld_err), 32'd0);
    tick();
    ld_req = 1'b0;
    #2;
    chk("mis_err", 32'(ld_err), 32'd1);
    tick();
    chk("mis_err_end", 32'(ld_err), 32'd0);
    ld_req = 1'b1; ld_addr = 32'h0000_2000;
    #2;
    chk("oor_gnt", 32'(ld_gnt), 32'd1);
    chk("oor_we", 32'(mem_we), 32'd0);
    tick();
    ld_req = 1'b1; ld_addr = 32'h0000_1ffc; ld_wdata = 32'hcafe_f00d;
    #2;
    chk("oor_err", 32'(ld_err), 32'd1);
    chk("top_gnt", 32'(ld_gnt), 32'd1);
    chk("top_we", 32'(mem_we), 32'd1);
    chk("top_addr", 32'(mem_addr), 32'h7ff);
    tick();
    ld_req = 1'b0;
    #2;
    chk("top_err", 32'(ld_err), 32'd0);
    fetch_req = 1'b1; fetch_pc = 32'h100;
    #1;
    chk("still_run", 32'(fetch_gnt), 32'd1);
    chk("fetch_addr", 32'(mem_addr), 32'h40);
    tick();

    // 6. Reset while fetch is being granted.
    rst_n = 1'b0; boot_done = 1'b0;
    #2;
    chk("rrst_fgnt", 32'(fetch_gnt), 32'd0);
    chk("rrst_stall", 32'(fetch_stall), 32'd1);
    chk("rrst_rvalid_pre", 32'(fetch_rvalid), 32'd1);
    tick();
    rst_n = 1'b1;
    #2;
    chk("rrst_rvalid", 32'(fetch_rvalid), 32'd0);
    chk("rrst_boot_fgnt", 32'(fetch_gnt), 32'd0);
    chk("rrst_boot_stall", 32'(fetch_stall), 32'd1);
    tick();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
